// File: rtl/apb_rr_master.sv
// apb_rr_master: round-robin APB master sharing one APB slave port among NREQ
// local requesters. Each requester issues single read/write commands. The
// block sequences the APB SETUP and ACCESS phases and returns one response
// per command.
// Optional build macro: APB_TIMEOUT_EN. When it is defined, an ACCESS phase
// that sees TIMEOUT cycles with PREADY low is aborted and answered with rsp_err=1.
//
// Handshake: a command is taken when req_valid[i] && req_ready[i]. req_ready
// is a combinational single-cycle pulse to the arbitration winner. The
// requester may change or drop its inputs after that cycle. rsp_valid[i]
// pulses for one cycle when requester i's transfer ends. rsp_rdata and
// rsp_err are qualified by that pulse, and rsp_rdata holds until the next
// response.
module apb_rr_master #(
  parameter int NREQ    = 2,
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ-1:0]  req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]  req_ready,
  output logic [NREQ-1:0]  rsp_valid,
  output logic [DW-1:0]    rsp_rdata,
  output logic             rsp_err,
  output logic             busy,
  output logic             PSEL,
  output logic             PENABLE,
  output logic             PWRITE,
  output logic [AW-1:0]    PADDR,
  output logic [DW-1:0]    PWDATA,
  input  logic [DW-1:0]    PRDATA,
  input  logic             PREADY
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [31:0] UNUSED_TIMEOUT_CFG = TIMEOUT;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   last_q;
  logic [IW-1:0]   owner_q;
  logic            pwrite_q;
  logic [AW-1:0]   paddr_q;
  logic [DW-1:0]   pwdata_q;
  logic [NREQ-1:0] rsp_valid_q;
  logic [DW-1:0]   rsp_rdata_q;

  logic [IW-1:0]   winner;
  logic            any_valid;
  logic            grant;
  logic            complete;
  logic            abort;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic            sel_write;

`ifdef APB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt_q;
  logic          rsp_err_q;
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // Round-robin search starting just after the last winner.
  always_comb begin
    int idx;
    winner    = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_q) + k) % NREQ;
      if (!any_valid && req_valid[idx]) begin
        any_valid = 1'b1;
        winner    = IW'(idx);
      end
    end
  end

  // Select the winning requester's command fields.
  always_comb begin
    sel_addr  = req_addr[int'(winner)*AW +: AW];
    sel_wdata = req_wdata[int'(winner)*DW +: DW];
    sel_write = req_write[winner];
  end

  // Next-state logic, grant and completion/abort decisions.
  always_comb begin
    state_d  = state_q;
    grant    = 1'b0;
    complete = 1'b0;
    abort    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_valid) begin
          grant   = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: begin
        if (PREADY) begin
          complete = 1'b1;
          if (any_valid) begin
            grant   = 1'b1;
            state_d = S_SETUP;
          end else begin
            state_d = S_IDLE;
          end
        end
`ifdef APB_TIMEOUT_EN
        // Abort on the TIMEOUT-th ACCESS cycle without PREADY; no grant here.
        else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          abort   = 1'b1;
          state_d = S_IDLE;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge PCLK) begin
    if (PRESET) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Command latch, round-robin pointer and response registers.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      last_q      <= IW'(NREQ - 1);
      owner_q     <= '0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
`ifdef APB_TIMEOUT_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= '0;
      if (grant) begin
        last_q   <= winner;
        owner_q  <= winner;
        pwrite_q <= sel_write;
        paddr_q  <= sel_addr;
        pwdata_q <= sel_wdata;
      end
      if (complete) begin
        rsp_valid_q <= NREQ'(1) << owner_q;
        rsp_rdata_q <= pwrite_q ? '0 : PRDATA;
`ifdef APB_TIMEOUT_EN
        rsp_err_q   <= 1'b0;
`endif
      end
`ifdef APB_TIMEOUT_EN
      if (abort) begin
        rsp_valid_q <= NREQ'(1) << owner_q;
        rsp_rdata_q <= '0;
        rsp_err_q   <= 1'b1;
      end
`endif
    end
  end

`ifdef APB_TIMEOUT_EN
  // Wait counter: cleared in SETUP, counts ACCESS cycles with PREADY low.
  always_ff @(posedge PCLK) begin
    if (PRESET)                             tcnt_q <= '0;
    else if (state_q == S_SETUP)            tcnt_q <= '0;
    else if (state_q == S_ACCESS && !PREADY) tcnt_q <= tcnt_q + 1'b1;
  end
`endif

  assign req_ready = grant ? (NREQ'(1) << winner) : '0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign busy      = (state_q != S_IDLE);
  assign PSEL      = (state_q != S_IDLE);
  assign PENABLE   = (state_q == S_ACCESS);
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// Directed bench for apb_rr_master (NREQ=2) with a 16-word APB slave model.
module tb_apb_rr_master;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [1:0]  req_valid, req_write, req_ready, rsp_valid;
  logic [63:0] req_addr, req_wdata;
  logic [31:0] rsp_rdata, PADDR, PWDATA, PRDATA;
  logic        rsp_err, busy, PSEL, PENABLE, PWRITE, PREADY;

  int n_checks = 0;
  int n_fail   = 0;
  logic [39:0] exp_q[$];

  // Slave model controls.
  logic [31:0] mem [16];
  logic        pready_r;
  int          acc_cnt;
  int          wait_cfg = 0;
  bit          stall = 0;

  apb_rr_master #(.NREQ(2), .DW(32), .AW(32), .TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  // Clock.
  always #5 PCLK = ~PCLK;

  // Slave with registered PREADY: at least two ACCESS cycles, plus wait_cfg.
  always @(posedge PCLK) begin
    if (PRESET) begin
      pready_r <= 1'b0;
      acc_cnt  <= 0;
    end else begin
      if (PSEL && PENABLE && !pready_r) begin
        acc_cnt  <= acc_cnt + 1;
        pready_r <= !stall && (acc_cnt >= wait_cfg);
      end else begin
        acc_cnt  <= 0;
        pready_r <= 1'b0;
      end
      if (PSEL && PENABLE && pready_r && PWRITE) mem[PADDR[5:2]] <= PWDATA;
    end
  end
  assign PREADY = pready_r;
  assign PRDATA = mem[PADDR[5:2]];

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance to the drive point just after the next rising edge.
  task automatic cyc();
    @(posedge PCLK);
    #1;
  endtask

  // One uncontended command; latency counted from the grant cycle.
  task automatic single(input string tag, input int idx, input bit wr,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int exp_lat, input logic [31:0] exp_rd);
    int lat, psel_at, pen_at;
    bit got, pwrite_seen;
    logic [31:0] paddr_seen, pwdata_seen;
    req_valid = '0;
    req_valid[idx] = 1'b1;
    req_write[idx] = wr;
    req_addr[idx*32 +: 32]  = addr;
    req_wdata[idx*32 +: 32] = wd;
    @(negedge PCLK);
    check_eq({tag, "_ready"}, req_ready, 64'(1) << idx);
    cyc();
    req_valid = '0;
    lat = 0; psel_at = -1; pen_at = -1; got = 0;
    paddr_seen = '0; pwdata_seen = '0; pwrite_seen = 0;
    while (lat < 60 && !got) begin
      @(negedge PCLK);
      lat++;
      if (PSEL && psel_at < 0) begin
        psel_at = lat; paddr_seen = PADDR; pwdata_seen = PWDATA; pwrite_seen = PWRITE;
      end
      if (PENABLE && pen_at < 0) pen_at = lat;
      if (rsp_valid != 0) got = 1;
      else cyc();
    end
    check_eq({tag, "_got_rsp"}, got, 1);
    check_eq({tag, "_latency"}, lat, exp_lat);
    check_eq({tag, "_psel_at"}, psel_at, 1);
    check_eq({tag, "_penable_at"}, pen_at, 2);
    check_eq({tag, "_paddr"}, paddr_seen, addr);
    check_eq({tag, "_pwrite"}, pwrite_seen, wr);
    if (wr) check_eq({tag, "_pwdata"}, pwdata_seen, wd);
    check_eq({tag, "_rsp_owner"}, rsp_valid, 64'(1) << idx);
    check_eq({tag, "_rdata"}, rsp_rdata, exp_rd);
    check_eq({tag, "_err"}, rsp_err, 0);
    cyc();
  endtask

  // Both requesters held valid for n transfers; grants must alternate
  // starting at 'first', three cycles apart, with busy high throughout.
  task automatic contend(input string tag, input bit wr,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input int n, input int first,
                         input logic [31:0] e0, input logic [31:0] e1);
    int grants, rsps, last_w, g;
    logic [31:0] w0, w1;
    logic [39:0] ent;
    grants = 0; rsps = 0; last_w = 0; w0 = d0; w1 = d1;
    exp_q.delete();
    req_write = {wr, wr};
    req_addr  = {a1, a0};
    req_wdata = {w1, w0};
    req_valid = 2'b11;
    for (int w = 0; w < 80 && rsps < n; w++) begin
      @(negedge PCLK);
      g = -1;
      if (rsp_valid != 0) begin
        if (exp_q.size() == 0) begin
          check_eq({tag, "_unexpected_rsp"}, rsp_valid, 0);
        end else begin
          ent = exp_q.pop_front();
          check_eq({tag, "_rsp_owner"}, rsp_valid, 64'(1) << ent[39:32]);
          check_eq({tag, "_rdata"}, rsp_rdata, ent[31:0]);
          check_eq({tag, "_err"}, rsp_err, 0);
        end
        rsps++;
      end
      if (grants > 0 && rsps < n) check_eq({tag, "_busy"}, busy, 1);
      if (req_ready != 0 && grants < n) begin
        g = req_ready[1] ? 1 : 0;
        check_eq({tag, "_grant_order"}, req_ready, 64'(1) << ((first + grants) % 2));
        if (grants > 0) check_eq({tag, "_grant_gap"}, w - last_w, 3);
        exp_q.push_back({8'(g), wr ? 32'h0 : (g == 1 ? e1 : e0)});
        grants++;
        last_w = w;
      end
      cyc();
      if (g == 0) w0 = w0 + 1;
      else if (g == 1) w1 = w1 + 1;
      req_wdata = {w1, w0};
      if (grants == n) req_valid = '0;
    end
    check_eq({tag, "_rsp_count"}, rsps, n);
  endtask

  initial begin
    logic [1:0] seen;
    foreach (mem[i]) mem[i] = '0;
    PRESET = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge PCLK);
    #1;
    PRESET = 1'b0;
    @(negedge PCLK);
    check_eq("rst_psel", PSEL, 0);
    check_eq("rst_penable", PENABLE, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_rsp_err", rsp_err, 0);
    check_eq("rst_rsp_rdata", rsp_rdata, 0);
    check_eq("rst_paddr", PADDR, 0);
    check_eq("rst_pwdata", PWDATA, 0);
    check_eq("rst_pwrite", PWRITE, 0);
    cyc();

    single("wr0", 0, 1'b1, 32'h4, 32'hDEADBEEF, 4, 32'h0);
    single("rd1", 1, 1'b0, 32'h4, 32'h0, 4, 32'hDEADBEEF);
    contend("rr_wr", 1'b1, 32'h10, 32'h14, 32'h11110001, 32'h22220001, 4, 0, 32'h0, 32'h0);
    contend("b2b_rd", 1'b0, 32'h10, 32'h14, 32'h0, 32'h0, 2, 0, 32'h11110002, 32'h22220002);
    wait_cfg = 3;
    single("wait_rd", 0, 1'b0, 32'h14, 32'h0, 7, 32'h22220002);
    wait_cfg = 5;

    // Reset during ACCESS of a requester-0 write to 0x8.
    req_valid = 2'b01; req_write = 2'b01;
    req_addr[31:0] = 32'h8; req_wdata[31:0] = 32'hA5A5A5A5;
    @(negedge PCLK);
    check_eq("rst_mid_ready", req_ready, 2'b01);
    cyc();
    req_valid = '0;
    cyc();
    @(negedge PCLK);
    check_eq("rst_mid_in_access", PENABLE, 1);
    cyc();
    PRESET = 1'b1;
    seen = '0;
    @(negedge PCLK);
    seen |= rsp_valid;
    cyc();
    PRESET = 1'b0;
    @(negedge PCLK);
    check_eq("rst_mid_psel", PSEL, 0);
    check_eq("rst_mid_penable", PENABLE, 0);
    check_eq("rst_mid_busy", busy, 0);
    check_eq("rst_mid_rdata", rsp_rdata, 0);
    for (int i = 0; i < 8; i++) begin
      seen |= rsp_valid;
      cyc();
      @(negedge PCLK);
    end
    check_eq("rst_mid_no_rsp", seen, 0);
    cyc();
    wait_cfg = 0;
    contend("post_rst", 1'b0, 32'h8, 32'h10, 32'h0, 32'h0, 2, 0, 32'h0, 32'h11110002);

`ifdef APB_TIMEOUT_EN
    begin
      int acc;
      bit got;
      stall = 1;
      req_write = '0; req_addr = {32'h14, 32'h10}; req_valid = 2'b11;
      @(negedge PCLK);
      check_eq("to_ready0", req_ready, 2'b01);
      cyc();
      req_valid = 2'b10;
      acc = 0; got = 0;
      for (int w = 0; w < 60 && !got; w++) begin
        @(negedge PCLK);
        if (PENABLE) acc++;
        if (rsp_valid != 0) begin
          got = 1;
          check_eq("to_owner", rsp_valid, 2'b01);
          check_eq("to_err", rsp_err, 1);
          check_eq("to_rdata", rsp_rdata, 0);
          check_eq("to_next_grant", req_ready, 2'b10);
        end
        cyc();
      end
      check_eq("to_got_rsp", got, 1);
      check_eq("to_access_cycles", acc, 16);
      req_valid = '0;
      stall = 0;
      got = 0;
      for (int w = 0; w < 60 && !got; w++) begin
        @(negedge PCLK);
        if (rsp_valid != 0) begin
          got = 1;
          check_eq("to_after_latency", w + 1, 4);
          check_eq("to_after_owner", rsp_valid, 2'b10);
          check_eq("to_after_rdata", rsp_rdata, 32'h22220002);
          check_eq("to_after_err", rsp_err, 0);
        end
        cyc();
      end
      check_eq("to_after_got", got, 1);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Watchdog.
  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/apb_rr_master.md
Name: apb_rr_master

Overview:
- Round-robin APB master that shares one APB slave port (the 16-word register/memory slave) between NREQ local requesters.
- Each requester issues single read/write commands over a valid/ready interface.
- The block arbitrates between requesters, sequences the APB SETUP/ACCESS phases, waits for PREADY, and returns read data or a write acknowledgement to the granted requester.
- It sits between the local requesters and the APB slave.

Parameters:
- NREQ, 2, number of requesters (2..8).
- DW, 32, data width.
- AW, 32, address width.
- TIMEOUT, 16, maximum ACCESS cycles before abort. Used only with APB_TIMEOUT_EN.

Ports:
- PCLK  input  1  clock; all logic on rising edge.
- PRESET  input  1  reset, synchronous, active-high.
- req_valid  input  NREQ  per-requester command valid.
- req_write  input  NREQ  per-requester command type: 1 = write, 0 = read.
- req_addr  input  NREQ*AW  per-requester address; requester i at bits [i*AW +: AW].
- req_wdata  input  NREQ*DW  per-requester write data; requester i at bits [i*DW +: DW].
- req_ready  output  NREQ  one-cycle accept pulse to the granted requester.
- rsp_valid  output  NREQ  one-cycle completion pulse to the owning requester.
- rsp_rdata  output  DW  read data, qualified by rsp_valid.
- rsp_err  output  1  timeout error, qualified by rsp_valid.
- busy  output  1  high when the state is not IDLE.
- PSEL  output  1  APB select.
- PENABLE  output  1  APB enable.
- PWRITE  output  1  APB direction.
- PADDR  output  AW  APB address.
- PWDATA  output  DW  APB write data.
- PRDATA  input  DW  APB read data.
- PREADY  input  1  APB ready.

Behaviour:
- Reset (PRESET high at an edge):
  - state = IDLE; all outputs 0.
  - Round-robin pointer last = NREQ-1, so requester 0 wins first.
  - Reset mid-transfer aborts immediately: PSEL/PENABLE = 0 next cycle, no rsp_valid for the aborted command.
- Arbitration:
  - Combinational over req_valid.
  - Search order is last+1, last+2, ... wrapping modulo NREQ.
  - The first asserted requester wins.
  - On grant: last <= winner.
- Grant point: IDLE with any req_valid, or ACCESS completion cycle with any req_valid (back-to-back).
- In the grant cycle:
  - req_ready[winner] = 1 (combinational, single bit).
  - Command latched into PWRITE/PADDR/PWDATA registers and owner index.
  - Requester may change or drop its inputs afterwards.
- States:
  - IDLE: PSEL=0, PENABLE=0. Goes to SETUP on grant, otherwise stays.
  - SETUP: PSEL=1, PENABLE=0, one cycle, then ACCESS.
  - ACCESS: PSEL=1, PENABLE=1; PADDR/PWRITE/PWDATA held stable.
- ACCESS exits:
  - PREADY=1 completes the transfer: next state is SETUP if a new grant occurs in that cycle, otherwise IDLE.
  - PREADY=0 holds ACCESS.
- The slave registers PREADY, so the minimum ACCESS length is 2 cycles. A PREADY left high from the previous transfer falls during SETUP, so it never completes the new ACCESS early.
- Response:
  - The cycle after completion: rsp_valid[owner] = 1 for one cycle.
  - rsp_rdata = PRDATA sampled at completion for reads, 0 for writes; rsp_err = 0.
  - rsp_rdata holds until the next response.
- Latency, uncontended transfer: grant in cycle 0, SETUP in cycle 1, ACCESS in cycles 2-3, rsp_valid in cycle 4.
- Back-to-back grant: the next SETUP immediately follows the completing ACCESS, with no IDLE cycle.
- A requester whose valid stays high after its grant re-competes; round-robin prevents starvation.
- With all NREQ requesters continuously valid, each is served once per NREQ transfers.
- Only one transfer is outstanding at any time.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments on each ACCESS cycle with PREADY=0.
  - When the counter reaches TIMEOUT, the block aborts: PSEL/PENABLE go to 0 and next state is IDLE. No back-to-back grant occurs in the abort cycle.
  - The following cycle: rsp_valid[owner] = 1, rsp_err = 1, rsp_rdata = 0.
- Not defined: no counter; ACCESS waits indefinitely for PREADY; rsp_err is tied 0.

Test Plan:
- Req0 write addr 0x4, data 0xDEADBEEF -> PSEL rises one cycle after req_ready[0], then PENABLE; rsp_valid[0] 4 cycles after grant; rsp_err=0.
- Req1 read addr 0x4 after the above -> rsp_valid[1] with rsp_rdata=0xDEADBEEF.
- req_valid=2'b11 held for 4 transfers after reset, each req0 writing 0x1..., req1 writing 0x2... -> grant order 0,1,0,1; back-to-back SETUPs with no IDLE cycle; busy stays 1 throughout.
- PRESET asserted during ACCESS of a write to addr 0x8 -> PSEL=PENABLE=0 next cycle; no rsp_valid; the next grant after reset goes to requester 0.
- APB_TIMEOUT_EN, TIMEOUT=16, PREADY forced 0 on a read -> abort after 16 ACCESS cycles; rsp_valid with rsp_err=1 and rsp_rdata=0; the next queued request then proceeds normally.
- Slave PREADY already 1 from the previous transfer during a back-to-back SETUP -> the new ACCESS still lasts 2 cycles and returns data for the new address.
